output_layer_seq: RTL and testbench
===================================

# output_layer_seq

Sequential output layer of the digit-classifier network. It computes the 10 output-neuron scores from a vector of hidden-layer activations using a single time-shared MAC. Each accumulated sum is shifted, passed through ReLU and saturated to an unsigned 8-bit score. The scores are presented as one packed 80-bit vector to the combinational argmax stage directly downstream.

## Interface
- N_IN, 30, number of hidden activations per neuron
- SHIFT, 4, arithmetic right shift applied to each accumulated sum before ReLU/saturation
- ACC_W, 24, signed accumulator width; must hold N_IN*255*128+128 without overflow
- ADDR_W, clog2(10*(N_IN+1)), weight-memory address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begins a run; sampled only in IDLE
- x_vec  in  N_IN*8  unsigned activations; element i at [8i+7:8i]; latched on accepted start
- w_rd_en  out  1  weight-memory read enable
- w_addr  out  ADDR_W  weight-memory address
- w_data  in  8  signed weight/bias; valid the cycle after the address is presented
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse when all 10 scores are final
- scores  out  80  unsigned score k at [8k+7:8k]
- scores_valid  out  1  high from DONE until the next accepted start

## Operation
- Memory layout: neuron k occupies addresses k*(N_IN+1) through k*(N_IN+1)+N_IN. The first N_IN entries are weights w[k][i]; the last entry is the bias b[k].
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start. x_vec is copied into an internal register and scores_valid is cleared.
  - RUN issues addresses 0 through 10*(N_IN+1)-1 on consecutive cycles with w_rd_en=1, then goes to DRAIN.
  - DRAIN lasts one cycle and receives the last datum, then goes to DONE.
  - DONE lasts one cycle (done=1), then goes to IDLE.
- Data path, one element per cycle:
  - A weight datum adds x[i]*w (8u×8s, sign-extended to ACC_W) to the accumulator.
  - A bias datum adds sign-extended b.
  - On a bias datum, the final sum S is post-processed and written to scores[k], and the accumulator clears for neuron k+1.
- Post-processing: q = S >>> SHIFT. The score is 0 if q<0, 255 if q>255, otherwise q[7:0].
- Elements are consumed with a counter pair (neuron k 0..9, element i 0..N_IN). The pair wraps i→0 and k→k+1 after the bias element; no address is skipped.
- Outside a run, scores hold their last values.

## Timing
- Reset values: FSM=IDLE; busy=0; done=0; scores_valid=0; scores=0; w_rd_en=0; w_addr=0; accumulator=0; counters=0.
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- Address a is presented in cycle a+1, and its data is consumed in cycle a+2.
- Score k is registered at the end of cycle (k+1)(N_IN+1)+1.
- done is high in cycle L = 10*(N_IN+1)+2, which is 312 at defaults. scores_valid rises in the same cycle.
- start while not in IDLE (RUN, DRAIN or DONE) is ignored. start held high through DONE launches a new run from IDLE on the following cycle.
- rst_n low mid-run: all state returns to reset values on the next edge, no done is produced, and partial scores are discarded (zeroed).
- Changes on x_vec after the start cycle have no effect on the current run.

## Structure
- Shared package nn_pkg holds:
  - NUM_OUT=10 and DW=8
  - the packed-score width NUM_OUT*DW=80 (used by the downstream argmax stage as well)
  - the FSM state enum
- Sub-module relu_sat (combinational): takes ACC_W-bit signed S and SHIFT, and outputs the 8-bit unsigned score.
- The top level holds the FSM, counters, address generator, x_vec latch, MAC and score registers.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> all outputs at reset values, w_rd_en=0, no done.
- All x=16, all weights=1, all biases=0 -> S=480, q=30. Every score byte is 0x1E, done in cycle 312, and w_addr sequence 0..309 with no gaps.
- Saturation/ReLU: x=255, w=127, b=127 -> every score 255. Same x with w=-128 and b=0 -> every score 0.
- Per-neuron distinct: x=16, neuron k weights=k, b=0 -> scores 0,30,60,...,240,255 (k=9 clips 270). With x_vec changed to all-0 at cycle 5, results are unchanged.
- Busy rejection: start pulse at cycle 100 -> ignored, done only at cycle 312. A second start at cycle 313 -> second done at cycle 625 with identical scores.
- Reset mid-run: rst_n=0 at cycle 150 -> busy=0, scores=0 and scores_valid=0 on the next cycle, no done ever produced.

Source files
------------

// File: rtl/nn_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nn_pkg : constants and FSM state type shared by the digit-classifier layers
// Revision: 1.0
// ---------------------------------------------------------------------------
package nn_pkg;

    localparam int NUM_OUT = 10;
    localparam int DW      = 8;
    localparam int SCORE_W = NUM_OUT * DW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/output_layer_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// output_layer_seq_if : control, weight-memory and score bundle of the layer
// Revision: 1.0
// ---------------------------------------------------------------------------
interface output_layer_seq_if
    import nn_pkg::*;
#(
    parameter int N_IN   = 30,
    parameter int ADDR_W = 9
);
    logic                 start;
    logic [N_IN*DW-1:0]   x_vec;
    logic                 w_rd_en;
    logic [ADDR_W-1:0]    w_addr;
    logic [DW-1:0]        w_data;
    logic                 busy;
    logic                 done;
    logic [SCORE_W-1:0]   scores;
    logic                 scores_valid;

    modport master (
        output start, x_vec, w_data,
        input  w_rd_en, w_addr, busy, done, scores, scores_valid
    );

    modport slave (
        input  start, x_vec, w_data,
        output w_rd_en, w_addr, busy, done, scores, scores_valid
    );
endinterface
`default_nettype wire

// File: rtl/output_layer_seq_relu_sat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// relu_sat : arithmetic shift, ReLU and unsigned 8-bit saturation of a sum
// Revision: 1.0
// ---------------------------------------------------------------------------
module relu_sat
    import nn_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SHIFT = 4
) (
    input  logic signed [ACC_W-1:0] s_i,
    output logic        [DW-1:0]    score_o
);
    logic signed [ACC_W-1:0] q_w;

    always_comb begin
        q_w = s_i >>> SHIFT;
        if (q_w[ACC_W-1]) begin
            score_o = '0;
        end else if (|q_w[ACC_W-2:DW]) begin
            score_o = '1;
        end else begin
            score_o = q_w[DW-1:0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/output_layer_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// output_layer_seq : 10-neuron output layer on one time-shared MAC
// Revision: 1.0
// ---------------------------------------------------------------------------
module output_layer_seq
    import nn_pkg::*;
#(
    parameter int N_IN   = 30,
    parameter int SHIFT  = 4,
    parameter int ACC_W  = 24,
    parameter int ADDR_W = $clog2(NUM_OUT * (N_IN + 1))
) (
    input  logic               clk,
    input  logic               rst_n,
    output_layer_seq_if.slave  bus
);
    localparam int LAST_ADDR = NUM_OUT * (N_IN + 1) - 1;
    localparam int IW        = $clog2(N_IN + 1);
    localparam int KW        = $clog2(NUM_OUT);
    localparam int PW        = 2 * DW + 2;

    state_t                  state_q, state_d;
    logic [DW-1:0]           x_q     [N_IN];
    logic [DW-1:0]           score_q [NUM_OUT];
    logic [ADDR_W-1:0]       w_addr_q;
    logic                    rd_en_q, vld_q, scores_valid_q;
    logic [IW-1:0]           i_q;
    logic [KW-1:0]           k_q;
    logic signed [ACC_W-1:0] acc_q;

    logic                    w_accept, w_last_addr, w_bias;
    logic [DW-1:0]           w_xi, w_score;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACC_W-1:0] w_term, w_sum;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    assign w_accept    = (state_q == ST_IDLE) && bus.start;
    assign w_last_addr = (w_addr_q == ADDR_W'(LAST_ADDR));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start)  state_d = ST_RUN;
            ST_RUN:   if (w_last_addr) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy         = (state_q != ST_IDLE);
        bus.done         = (state_q == ST_DONE);
        bus.w_rd_en      = rd_en_q;
        bus.w_addr       = w_addr_q;
        bus.scores_valid = scores_valid_q;
    end

    // 8u x 8s product: zero-extend x, sign-extend w to 9 bits each
    assign w_bias = (i_q == IW'(N_IN));
    assign w_xi   = w_bias ? '0 : x_q[i_q];
    assign w_prod = $signed({1'b0, w_xi}) * $signed({bus.w_data[DW-1], bus.w_data});
    assign w_term = w_bias ? {{(ACC_W-DW){bus.w_data[DW-1]}}, bus.w_data}
                           : {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
    assign w_sum  = acc_q + w_term;

    relu_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_relu_sat (
        .s_i     (w_sum),
        .score_o (w_score)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < N_IN; n++)    x_q[n]     <= '0;
            for (int n = 0; n < NUM_OUT; n++) score_q[n] <= '0;
            w_addr_q       <= '0;
            rd_en_q        <= 1'b0;
            vld_q          <= 1'b0;
            i_q            <= '0;
            k_q            <= '0;
            acc_q          <= '0;
            scores_valid_q <= 1'b0;
        end else if (w_accept) begin
            for (int n = 0; n < N_IN; n++) x_q[n] <= bus.x_vec[n*DW +: DW];
            w_addr_q       <= '0;
            rd_en_q        <= 1'b1;
            vld_q          <= 1'b0;
            i_q            <= '0;
            k_q            <= '0;
            acc_q          <= '0;
            scores_valid_q <= 1'b0;
        end else begin
            vld_q <= rd_en_q;
            if (rd_en_q) begin
                if (w_last_addr) begin
                    rd_en_q  <= 1'b0;
                    w_addr_q <= '0;
                end else begin
                    w_addr_q <= w_addr_q + 1'b1;
                end
            end
            if (vld_q) begin
                if (w_bias) begin
                    score_q[k_q] <= w_score;
                    acc_q        <= '0;
                    i_q          <= '0;
                    k_q          <= (k_q == KW'(NUM_OUT - 1)) ? '0 : k_q + 1'b1;
                end else begin
                    acc_q <= w_sum;
                    i_q   <= i_q + 1'b1;
                end
            end
            if (state_q == ST_DRAIN) scores_valid_q <= 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < NUM_OUT; g++) begin : g_pack
            assign bus.scores[g*DW +: DW] = score_q[g];
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_output_layer_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_output_layer_seq : directed vectors with a queue-based done/score monitor
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_output_layer_seq;
    import nn_pkg::*;

    localparam int N_IN   = 30;
    localparam int ADDR_W = 9;
    localparam int NWORDS = 310;
    localparam int LAT    = 312;

    typedef struct {
        logic [SCORE_W-1:0] sc;
        int                 cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_layer_seq_if #(.N_IN(N_IN), .ADDR_W(ADDR_W)) bus();

    output_layer_seq #(
        .N_IN   (N_IN),
        .SHIFT  (4),
        .ACC_W  (24),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [7:0] wmem [NWORDS];
    always @(posedge clk) if (bus.w_rd_en) bus.w_data <= wmem[bus.w_addr];

    int   cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    int   total = 0;
    int   bad = 0;
    int   t_start = 0;
    int   addr_cnt = 0;
    int   addr_bad = 0;
    int   done_seen = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [SCORE_W-1:0] act,
                         input logic [SCORE_W-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Monitor: every done pops one expected result
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus.done) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("scores", bus.scores, e.sc);
                check("done_cycle", cnt, e.cyc);
                check("valid_at_done", {79'd0, bus.scores_valid}, 1);
            end
        end
    end

    // Address a must appear in cycle a+1 of the latest run
    always @(negedge clk) begin
        if (rst_n && bus.w_rd_en) begin
            addr_cnt++;
            if (int'(bus.w_addr) != cnt - t_start - 1) addr_bad++;
        end
    end

    task automatic set_x(input int v);
        for (int i = 0; i < N_IN; i++) bus.x_vec[8*i +: 8] = 8'(v);
    endtask

    task automatic load_mem(input int w, input int b, input bit per_k);
        for (int k = 0; k < NUM_OUT; k++) begin
            for (int i = 0; i < N_IN; i++) wmem[k*(N_IN+1)+i] = per_k ? 8'(k) : 8'(w);
            wmem[k*(N_IN+1)+N_IN] = 8'(b);
        end
    endtask

    task automatic launch(output int t0);
        @(negedge clk);
        bus.start = 1'b1;
        t0        = cnt;
        t_start   = cnt;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic push(input logic [SCORE_W-1:0] sc, input int cyc);
        exp_t e;
        e.sc  = sc;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int target);
        while (cnt < target) @(negedge clk);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 800 && sb.size() != 0; n++) @(negedge clk);
        check("timeout", sb.size(), 0);
    endtask

    initial begin : stim
        int                 t0;
        int                 snap_c, snap_b;
        logic [7:0]         e3 [NUM_OUT];
        logic [SCORE_W-1:0] v3;

        bus.start = 1'b0;
        set_x(0);
        load_mem(0, 0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",   {79'd0, bus.busy}, 0);
        check("rst_done",   {79'd0, bus.done}, 0);
        check("rst_valid",  {79'd0, bus.scores_valid}, 0);
        check("rst_scores", bus.scores, 0);
        check("rst_rd_en",  {79'd0, bus.w_rd_en}, 0);
        check("rst_addr",   {71'd0, bus.w_addr}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // x=16, w=1, b=0: 480>>>4 = 30
        load_mem(1, 0, 1'b0);
        set_x(16);
        snap_c = addr_cnt;
        snap_b = addr_bad;
        launch(t0);
        push({NUM_OUT{8'h1E}}, t0 + LAT);
        check("busy_c1",  {79'd0, bus.busy}, 1);
        check("valid_c1", {79'd0, bus.scores_valid}, 0);
        check("rd_en_c1", {79'd0, bus.w_rd_en}, 1);
        wait_done();
        check("addr_count", addr_cnt - snap_c, NWORDS);
        check("addr_order", addr_bad - snap_b, 0);
        @(negedge clk);
        check("idle_busy",  {79'd0, bus.busy}, 0);
        check("idle_valid", {79'd0, bus.scores_valid}, 1);

        // Positive saturation
        load_mem(127, 127, 1'b0);
        set_x(255);
        launch(t0);
        push({NUM_OUT{8'hFF}}, t0 + LAT);
        wait_done();

        // Negative sums clip to zero
        load_mem(-128, 0, 1'b0);
        launch(t0);
        push({NUM_OUT{8'h00}}, t0 + LAT);
        wait_done();

        // Per-neuron weights k; x changes after start are ignored
        e3 = '{8'd0, 8'd30, 8'd60, 8'd90, 8'd120, 8'd150, 8'd180, 8'd210, 8'd240, 8'd255};
        for (int k = 0; k < NUM_OUT; k++) v3[8*k +: 8] = e3[k];
        load_mem(0, 0, 1'b1);
        set_x(16);
        launch(t0);
        push(v3, t0 + LAT);
        wait_until(t0 + 5);
        set_x(0);
        wait_done();

        // Start while busy is ignored; start right after DONE runs again
        set_x(16);
        launch(t0);
        push(v3, t0 + LAT);
        wait_until(t0 + 100);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_until(t0 + 313);
        bus.start = 1'b1;
        push(v3, t0 + 313 + LAT);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();

        // Reset mid-run discards everything
        launch(t0);
        wait_until(t0 + 150);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy",   {79'd0, bus.busy}, 0);
        check("mid_rst_scores", bus.scores, 0);
        check("mid_rst_valid",  {79'd0, bus.scores_valid}, 0);
        check("mid_rst_rd_en",  {79'd0, bus.w_rd_en}, 0);
        check("mid_rst_done",   {79'd0, bus.done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        check("done_count", done_seen, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
